// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: counter encoding, FSM states, counter update.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bpu_pkg;

  // Opcode of conditional branches as seen in the EXE stage
  localparam logic [6:0] OP_BTYPE = 7'b1100011;

  // 2-bit saturating direction counter; bit 1 is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    STK = 2'b11
  } ctr_t;

  // INIT walks the table clearing entries, RUN serves predictions
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Saturating step of the direction counter toward the resolved outcome
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? STK : WNT;
      STK:     n = taken ? STK : WT;
      default: n = SNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bpu_ctrl_if.sv
// Bundle of IF-lookup, EXE-resolve and status signals between the pipeline and the BPU.
// Latency: n/a (wiring only).
// Backpressure: stalls travel on Istall/Dstall; the BPU never pushes back on the pipeline.
interface bpu_ctrl_if;
  // IF-stage lookup
  logic [31:0] pc_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;

  // EXE-stage resolution
  logic [6:0]  opcode_ID_EXE;
  logic [31:0] pc_EXE;
  logic [31:0] target_EXE;
  logic        jump_sel;
  logic        pred_taken_EXE;
  logic [31:0] pred_target_EXE;

  // Pipeline control
  logic        Istall;
  logic        Dstall;
  logic        flush_tbl;
  logic        ready;
  logic        flush;
  logic [31:0] redirect_pc;

  // Performance counters
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  // Pipeline side: drives lookups and resolutions, consumes predictions and flushes
  modport master (
    output pc_IF, opcode_ID_EXE, pc_EXE, target_EXE, jump_sel,
           pred_taken_EXE, pred_target_EXE, Istall, Dstall, flush_tbl,
    input  ready, pred_taken_IF, pred_target_IF, flush, redirect_pc,
           br_cnt, miss_cnt
  );

  // Predictor side
  modport slave (
    input  pc_IF, opcode_ID_EXE, pc_EXE, target_EXE, jump_sel,
           pred_taken_EXE, pred_target_EXE, Istall, Dstall, flush_tbl,
    output ready, pred_taken_IF, pred_target_IF, flush, redirect_pc,
           br_cnt, miss_cnt
  );
endinterface

// File: rtl/bpu_table.sv
// Direct-mapped prediction table: valid/tag/target/counter per entry, no reset on storage.
// Latency: lookup read is combinational; clear and update land on the next clk edge.
// Backpressure: none; INIT clears take priority over updates, which the controller gates anyway.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  state_t           state,
  // lookup read port
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output ctr_t             rd_ctr,
  // clear port, active while the FSM walks the table
  input  logic [IDX_W-1:0] clr_idx,
  // resolve update port, read-modify-write of the addressed entry
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic clr_en;
  logic wr_upd;
  logic upd_hit;

  // Asynchronous lookup read; returns the pre-write entry when addresses collide
  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    rd_ctr    = ctr_q[rd_idx];
  end

  // Write-port source select: the clear walker owns the port in INIT, resolves in RUN
  always_comb begin
    clr_en  = (state == INIT);
    wr_upd  = (state == RUN) && upd_en;
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  // Single write port; tag/target are left stale on clear since valid=0 masks them
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
      ctr_q[clr_idx]   <= SNT;
    end else if (wr_upd) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/bpu_ctrl.sv
// Branch predictor controller: table init walk, IF lookup, EXE resolve/update, mispredict flush.
// Latency: lookup and flush/redirect are combinational; table and counter updates land next edge.
// Backpressure: a stalled pipeline holds off resolution entirely; the init walk ignores stalls.
module bpu_ctrl
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  bpu_ctrl_if.slave    bus
);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic [31:0]      br_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic             ready;
  logic             stall;
  logic             res;
  logic             mp;
  logic             upd_en;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  ctr_t             rd_ctr;
  logic             hit;

  // Upper and byte-offset PC bits play no part in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_IF[31:IDX_W+TAG_W+2], bus.pc_IF[1:0]};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // FSM next state: soft flush restarts the walk, last cleared entry enters RUN
  always_comb begin
    state_d = state_q;
    if (bus.flush_tbl) begin
      state_d = INIT;
    end else if ((state_q == INIT) && (init_idx_q == IDX_W'(ENTRIES - 1))) begin
      state_d = RUN;
    end
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == RUN);
  end

  // Init walker: one entry per cycle, restarted by a soft flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx_q <= '0;
    end else if (bus.flush_tbl) begin
      init_idx_q <= '0;
    end else if (state_q == INIT) begin
      init_idx_q <= init_idx_q + 1'b1;
    end
  end

  // Index/tag extraction for the fetch and execute PCs
  always_comb begin
    lk_idx = bus.pc_IF[IDX_W+1:2];
    lk_tag = bus.pc_IF[IDX_W+2 +: TAG_W];
    ex_idx = bus.pc_EXE[IDX_W+1:2];
    ex_tag = bus.pc_EXE[IDX_W+2 +: TAG_W];
  end

  // Resolve/mispredict detection; a flush fires in any state, table writes only in RUN
  always_comb begin
    stall  = bus.Istall | bus.Dstall;
    res    = (bus.opcode_ID_EXE == OP_BTYPE) && !stall;
    mp     = res && ((bus.jump_sel != bus.pred_taken_EXE) ||
                     (bus.jump_sel && bus.pred_taken_EXE &&
                      (bus.target_EXE != bus.pred_target_EXE)));
    upd_en = res && ready && !bus.flush_tbl;
  end

  // Prediction for the fetch PC; only a valid, tag-matching entry in RUN counts
  always_comb begin
    hit = ready && rd_valid && (rd_tag == lk_tag);
  end

  // Resolved-branch and mispredict counters; wrap naturally, survive soft flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (res) br_cnt_q   <= br_cnt_q + 32'd1;
      if (mp)  miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  bpu_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk        (clk),
    .state      (state_q),
    .rd_idx     (lk_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_ctr     (rd_ctr),
    .clr_idx    (init_idx_q),
    .upd_en     (upd_en),
    .upd_idx    (ex_idx),
    .upd_tag    (ex_tag),
    .upd_target (bus.target_EXE),
    .upd_taken  (bus.jump_sel)
  );

  assign bus.ready          = ready;
  assign bus.pred_taken_IF  = hit & rd_ctr[1];
  assign bus.pred_target_IF = hit ? rd_target : 32'd0;
  assign bus.flush          = mp;
  assign bus.redirect_pc    = !mp ? 32'd0 :
                              (bus.jump_sel ? bus.target_EXE : bus.pc_EXE + 32'd4);
  assign bus.br_cnt         = br_cnt_q;
  assign bus.miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed bench for bpu_ctrl: init walk, allocate, counter training, stalls, target miss, soft flush.
// Latency: inputs change on negedge, combinational outputs sampled 1ns later, state checked a cycle on.
// Backpressure: exercised through Dstall on a pending resolve.
module tb_bpu_ctrl;
  import bpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  bpu_ctrl_if bus();

  bpu_ctrl #(.ENTRIES(16), .IDX_W(4), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_exe();
    bus.opcode_ID_EXE   = 7'b0010011;
    bus.pc_EXE          = 32'd0;
    bus.target_EXE      = 32'd0;
    bus.jump_sel        = 1'b0;
    bus.pred_taken_EXE  = 1'b0;
    bus.pred_target_EXE = 32'd0;
    bus.Istall          = 1'b0;
    bus.Dstall          = 1'b0;
    bus.flush_tbl       = 1'b0;
  endtask

  task automatic drive_exe(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic js, input logic pt, input logic [31:0] ptg);
    bus.opcode_ID_EXE   = op;
    bus.pc_EXE          = pc;
    bus.target_EXE      = tgt;
    bus.jump_sel        = js;
    bus.pred_taken_EXE  = pt;
    bus.pred_target_EXE = ptg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_exe();
    bus.pc_IF = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", bus.ready); end
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %0b want 0", bus.flush); end
    n_vec++; if (bus.br_cnt !== 32'd0) begin n_err++; $display("FAIL reset_br_cnt got %0h want 0", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_miss_cnt got %0h want 0", bus.miss_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL init_ready cyc %0d got %0b want 0", i, bus.ready); end
      n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL init_pred cyc %0d got %0b want 0", i, bus.pred_taken_IF); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL init_done_ready got %0b want 1", bus.ready); end
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL init_done_pred got %0b want 0", bus.pred_taken_IF); end
  endtask

  task automatic test_allocate();
    @(negedge clk);
    bus.pc_IF = 32'h100;
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL alloc_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h200) begin n_err++; $display("FAIL alloc_redirect got %0h want 200", bus.redirect_pc); end
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL alloc_no_bypass got %0b want 0", bus.pred_taken_IF); end
    @(negedge clk);
    idle_exe();
    #1;
    n_vec++; if (bus.pred_taken_IF !== 1'b1) begin n_err++; $display("FAIL alloc_pred got %0b want 1", bus.pred_taken_IF); end
    n_vec++; if (bus.pred_target_IF !== 32'h200) begin n_err++; $display("FAIL alloc_target got %0h want 200", bus.pred_target_IF); end
    n_vec++; if (bus.br_cnt !== 32'd1) begin n_err++; $display("FAIL alloc_br_cnt got %0d want 1", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd1) begin n_err++; $display("FAIL alloc_miss_cnt got %0d want 1", bus.miss_cnt); end
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL alloc_flush_drop got %0b want 0", bus.flush); end
  endtask

  task automatic test_not_taken();
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200);
    #1;
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL nt1_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h104) begin n_err++; $display("FAIL nt1_redirect got %0h want 104", bus.redirect_pc); end
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL nt1_pred got %0b want 0", bus.pred_taken_IF); end
    n_vec++; if (bus.pred_target_IF !== 32'h200) begin n_err++; $display("FAIL nt1_target got %0h want 200", bus.pred_target_IF); end
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL nt2_flush got %0b want 0", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL nt2_redirect got %0h want 0", bus.redirect_pc); end
    @(negedge clk);
    // a non-branch with taken-looking fields must leave everything alone
    drive_exe(7'b0110011, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    #1;
    n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL nonbr_flush got %0b want 0", bus.flush); end
    @(negedge clk);
    idle_exe();
    #1;
    n_vec++; if (bus.br_cnt !== 32'd3) begin n_err++; $display("FAIL nt_br_cnt got %0d want 3", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd2) begin n_err++; $display("FAIL nt_miss_cnt got %0d want 2", bus.miss_cnt); end
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL nt2_pred got %0b want 0", bus.pred_taken_IF); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    bus.Dstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL stall_flush cyc %0d got %0b want 0", i, bus.flush); end
      n_vec++; if (bus.br_cnt !== 32'd3) begin n_err++; $display("FAIL stall_br_cnt cyc %0d got %0d want 3", i, bus.br_cnt); end
      @(negedge clk);
    end
    bus.Dstall = 1'b0;
    #1;
    n_vec++; if (bus.br_cnt !== 32'd3) begin n_err++; $display("FAIL stall_end_br_cnt got %0d want 3", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd2) begin n_err++; $display("FAIL stall_end_miss_cnt got %0d want 2", bus.miss_cnt); end
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL unstall_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h200) begin n_err++; $display("FAIL unstall_redirect got %0h want 200", bus.redirect_pc); end
    @(negedge clk);
    idle_exe();
    #1;
    n_vec++; if (bus.br_cnt !== 32'd4) begin n_err++; $display("FAIL unstall_br_cnt got %0d want 4", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd3) begin n_err++; $display("FAIL unstall_miss_cnt got %0d want 3", bus.miss_cnt); end
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL unstall_pred got %0b want 0", bus.pred_taken_IF); end
  endtask

  task automatic test_target();
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b1, 1'b1, 32'h300);
    #1;
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL tgt_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h200) begin n_err++; $display("FAIL tgt_redirect got %0h want 200", bus.redirect_pc); end
    @(negedge clk);
    idle_exe();
    #1;
    n_vec++; if (bus.miss_cnt !== 32'd4) begin n_err++; $display("FAIL tgt_miss_cnt got %0d want 4", bus.miss_cnt); end
    n_vec++; if (bus.pred_taken_IF !== 1'b1) begin n_err++; $display("FAIL tgt_pred got %0b want 1", bus.pred_taken_IF); end
    bus.pc_IF = 32'h140;
    #1;
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL tagmiss_pred got %0b want 0", bus.pred_taken_IF); end
    n_vec++; if (bus.pred_target_IF !== 32'h0) begin n_err++; $display("FAIL tagmiss_target got %0h want 0", bus.pred_target_IF); end
    bus.pc_IF = 32'h100;
    // two correct taken resolves push the counter to 11 and hold it there
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200);
      #1;
      n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL hit_flush %0d got %0b want 0", i, bus.flush); end
    end
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200);
    #1;
    n_vec++; if (bus.redirect_pc !== 32'h104) begin n_err++; $display("FAIL sat_redirect got %0h want 104", bus.redirect_pc); end
    @(negedge clk);
    drive_exe(OP_BTYPE, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 32'h10);
    #1;
    n_vec++; if (bus.pred_taken_IF !== 1'b1) begin n_err++; $display("FAIL sat_pred got %0b want 1", bus.pred_taken_IF); end
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL wrap_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL wrap_redirect got %0h want 0", bus.redirect_pc); end
    @(negedge clk);
    idle_exe();
    #1;
    n_vec++; if (bus.br_cnt !== 32'd9) begin n_err++; $display("FAIL tgt_br_cnt got %0d want 9", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd6) begin n_err++; $display("FAIL tgt_miss_cnt2 got %0d want 6", bus.miss_cnt); end
  endtask

  task automatic test_flush_tbl();
    @(negedge clk);
    bus.pc_IF = 32'h208;
    drive_exe(OP_BTYPE, 32'h208, 32'h400, 1'b1, 1'b0, 32'h0);
    bus.flush_tbl = 1'b1;
    #1;
    n_vec++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL ftbl_flush got %0b want 1", bus.flush); end
    n_vec++; if (bus.redirect_pc !== 32'h400) begin n_err++; $display("FAIL ftbl_redirect got %0h want 400", bus.redirect_pc); end
    @(negedge clk);
    idle_exe();
    for (int i = 0; i < 16; i++) begin
      #1;
      n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ftbl_ready cyc %0d got %0b want 0", i, bus.ready); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL ftbl_done_ready got %0b want 1", bus.ready); end
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL ftbl_no_alloc got %0b want 0", bus.pred_taken_IF); end
    n_vec++; if (bus.br_cnt !== 32'd10) begin n_err++; $display("FAIL ftbl_br_cnt got %0d want 10", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd7) begin n_err++; $display("FAIL ftbl_miss_cnt got %0d want 7", bus.miss_cnt); end
    bus.pc_IF = 32'h100;
    #1;
    n_vec++; if (bus.pred_taken_IF !== 1'b0) begin n_err++; $display("FAIL ftbl_old_pred got %0b want 0", bus.pred_taken_IF); end
    n_vec++; if (bus.pred_target_IF !== 32'h0) begin n_err++; $display("FAIL ftbl_old_target got %0h want 0", bus.pred_target_IF); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rst_run_ready got %0b want 0", bus.ready); end
    n_vec++; if (bus.br_cnt !== 32'd0) begin n_err++; $display("FAIL rst_run_br_cnt got %0d want 0", bus.br_cnt); end
    n_vec++; if (bus.miss_cnt !== 32'd0) begin n_err++; $display("FAIL rst_run_miss_cnt got %0d want 0", bus.miss_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_not_taken();
    test_stall();
    test_target();
    test_flush_tbl();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
